sr04_scheduler: RTL
===================

# sr04_scheduler

Measurement scheduler for the SR04 ultrasonic path. It sits between the user/system request sources and the SR04 controller, and decides when the controller fires. It merges manual requests and a periodic auto-mode request into single start pulses, enforces the sensor's minimum inter-measurement gap, and detects missing echoes by timeout. It also holds the last valid distance for downstream display logic.

## Interface
- DIST_W, 24, distance width (matches controller output)
- GAP_US, 60000, minimum µs from end of one measurement to the next start
- TIMEOUT_US, 40000, max µs from start to controller done before declaring timeout
- PERIOD_US, 100000, auto-mode request period in µs
- CNT_W, 17, µs counter width; must hold max(GAP_US, TIMEOUT_US, PERIOD_US)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_tick_1us  in  1  one-clk pulse every 1 µs from the shared tick generator
- i_manual_req  in  1  one-clk request pulse (debounced button)
- i_auto_en  in  1  level; enables periodic requests
- i_meas_done  in  1  one-clk pulse from controller: distance valid
- i_distance  in  DIST_W  controller distance, sampled on i_meas_done
- o_start  out  1  one-clk start pulse to controller
- o_distance  out  DIST_W  last valid distance (registered)
- o_valid  out  1  one-clk pulse when o_distance updates
- o_timeout  out  1  sticky; set on timeout, cleared on next valid result
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- Pending flag `pend` (single depth). Set by i_manual_req, or by auto-timer expiry while i_auto_en=1. Cleared when START is entered. Multiple or simultaneous requests collapse into one.
- IDLE: if pend=1 or a request arrives this cycle → START.
- START: o_start=1 for exactly this cycle; clear µs counter → WAIT_DONE.
- WAIT_DONE: count i_tick_1us.
  - On i_meas_done: latch i_distance into o_distance, pulse o_valid, clear o_timeout → GAP.
  - Else if count reaches TIMEOUT_US: set o_timeout, keep o_distance → GAP.
  - If done and timeout occur in the same cycle, done wins.
- GAP: clear the counter on entry; after GAP_US ticks → IDLE. Requests arriving here set pend and are served from IDLE.
- i_meas_done outside WAIT_DONE is ignored (no latch, no o_valid).
- Auto timer counts ticks while i_auto_en=1 and wraps at PERIOD_US-1; it sets pend on the wrap. i_auto_en=0 holds the timer at 0 but does not clear an existing pend.
- Counters saturate and never wrap within a state.

## Timing
- Reset (rst=0, async): state=IDLE, pend=0, all counters 0, o_start=0, o_distance=0, o_valid=0, o_timeout=0, o_busy=0.
- Request in IDLE at edge n → o_start high during cycle n+1 → WAIT_DONE from n+2.
- i_meas_done at edge n → o_distance/o_valid updated at n+1.
- Timeout declared on the clk edge where the TIMEOUT_US-th tick is counted; o_timeout high the next cycle.
- GAP→IDLE on the edge of the GAP_US-th tick. A pending request yields o_start 2 cycles later (IDLE, then START).
- Reset asserted mid-measurement aborts immediately. No o_start or o_valid is produced after release until a new request arrives.

## Structure
- Package sr04_pkg: state enum (IDLE, START, WAIT_DONE, GAP), DIST_W, default GAP_US/TIMEOUT_US/PERIOD_US constants.
- One sub-module, sr04_us_timer: tick-gated counter with sync clear, saturation, and a terminal-count compare output. Instantiated twice: phase counter (WAIT_DONE/GAP) and auto-period timer.

## Test plan
Use GAP_US=10, TIMEOUT_US=20, PERIOD_US=50, tick every 4 clk.
- Manual request in IDLE; done after 8 ticks with i_distance=0x0000AB → one o_start; o_distance=0x0000AB; one o_valid; o_timeout=0; IDLE 10 ticks after done.
- Request issued with no i_meas_done → o_timeout=1 after 20 ticks, o_distance unchanged. A following successful request with distance 0x12 clears o_timeout and shows 0x12.
- Three manual pulses during WAIT_DONE/GAP → exactly one extra o_start, issued 2 clk after GAP ends.
- i_auto_en=1 for 200 ticks with done returned at 5 ticks each → 4 o_start pulses spaced 50 ticks apart. Manual and auto request in the same cycle → a single o_start.
- i_meas_done and timeout on the same cycle → o_valid=1, o_timeout=0. Stray i_meas_done in IDLE/GAP → no o_valid.
- rst=0 in WAIT_DONE → all outputs 0 at once. After release, no o_start until a new request; a late i_meas_done is ignored.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared types and default timing constants for the SR04 measurement path.
// All timing values are in microseconds, counted with the shared 1 us tick.
package sr04_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    localparam int DIST_W_DFLT     = 24;
    localparam int GAP_US_DFLT     = 60000;
    localparam int TIMEOUT_US_DFLT = 40000;
    localparam int PERIOD_US_DFLT  = 100000;
    localparam int CNT_W_DFLT      = 17;

endpackage

// File: rtl/sr04_us_timer.sv
// Tick-gated microsecond counter with synchronous clear and saturation at i_tc.
// o_hit flags the cycle whose tick brings the count up to i_tc.
module sr04_us_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;

    // Combinational so the owner can act on the same edge that counts the last tick.
    assign o_hit = i_en && i_tick && (count_reg == i_tc - CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (i_clr) begin
            count_reg <= '0;
        end else if (i_en && i_tick && (count_reg != i_tc)) begin
            count_reg <= count_reg + CNT_ONE;
        end
    end

endmodule

// File: rtl/sr04_scheduler.sv
// Decides when the SR04 controller fires: merges manual and periodic requests,
// enforces the post-measurement gap, flags missing echoes and holds the last distance.
module sr04_scheduler
    import sr04_pkg::*;
#(
    parameter int DIST_W     = DIST_W_DFLT,
    parameter int GAP_US     = GAP_US_DFLT,
    parameter int TIMEOUT_US = TIMEOUT_US_DFLT,
    parameter int PERIOD_US  = PERIOD_US_DFLT,
    parameter int CNT_W      = CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick_1us,
    input  logic              i_manual_req,
    input  logic              i_auto_en,
    input  logic              i_meas_done,
    input  logic [DIST_W-1:0] i_distance,
    output logic              o_start,
    output logic [DIST_W-1:0] o_distance,
    output logic              o_valid,
    output logic              o_timeout,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(GAP_US);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] PERIOD_TC  = CNT_W'(PERIOD_US);

    state_t            state_reg;
    logic              pend_reg;
    logic              start_reg;
    logic              valid_reg;
    logic              timeout_reg;
    logic              busy_reg;
    logic [DIST_W-1:0] distance_reg;

    logic              phase_clr;
    logic              phase_en;
    logic [CNT_W-1:0]  phase_tc;
    logic              phase_hit;
    logic              auto_clr;
    logic              auto_hit;
    logic              req;

    // One counter serves both timed states; it restarts from zero on every state change.
    always_comb begin
        phase_en  = (state_reg == WAIT_DONE) || (state_reg == GAP);
        phase_tc  = (state_reg == GAP) ? GAP_TC : TIMEOUT_TC;
        phase_clr = (state_reg == IDLE) || (state_reg == START) ||
                    ((state_reg == WAIT_DONE) && (i_meas_done || phase_hit));
    end

    sr04_us_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (phase_clr),
        .i_en   (phase_en),
        .i_tick (i_tick_1us),
        .i_tc   (phase_tc),
        .o_hit  (phase_hit)
    );

    // Auto timer free-runs while enabled and restarts itself on each period wrap.
    assign auto_clr = !i_auto_en || auto_hit;

    sr04_us_timer #(
        .CNT_W (CNT_W)
    ) u_auto_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (auto_clr),
        .i_en   (i_auto_en),
        .i_tick (i_tick_1us),
        .i_tc   (PERIOD_TC),
        .o_hit  (auto_hit)
    );

    assign req = i_manual_req || auto_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            pend_reg     <= 1'b0;
            start_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            distance_reg <= '0;
        end else begin
            start_reg <= 1'b0;
            valid_reg <= 1'b0;

            // Single-depth pending flag: a request consumed by IDLE this cycle is not re-queued.
            if ((state_reg == IDLE) && (pend_reg || req)) begin
                pend_reg <= 1'b0;
            end else if (req) begin
                pend_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (pend_reg || req) begin
                        state_reg <= START;
                        start_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                START: begin
                    state_reg <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A result arriving on the timeout edge still counts as a result.
                    if (i_meas_done) begin
                        distance_reg <= i_distance;
                        valid_reg    <= 1'b1;
                        timeout_reg  <= 1'b0;
                        state_reg    <= GAP;
                    end else if (phase_hit) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (phase_hit) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_start    = start_reg;
    assign o_distance = distance_reg;
    assign o_valid    = valid_reg;
    assign o_timeout  = timeout_reg;
    assign o_busy     = busy_reg;

endmodule
